alarm_controller: RTL and testbench

Top-level arming state machine for the anti-theft system. It takes arm/disarm requests from the keypad logic and an intrusion sensor, and runs exit and entry delay countdowns in whole seconds. It drives `siren_en`, which feeds the `enable` input of the downstream siren tone generator, so the siren sounds only in the ALARM state.

---
 rtl/alarm_controller.sv | 221 ++++++++++++++++++++++
 tb/tb_alarm_controller.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/alarm_controller.sv
`default_nettype none
// ============================================================================
// Module   : alarm_controller
// Purpose  : Arming state machine for the anti-theft system. Accepts arm /
//            disarm pulses from the keypad logic and a raw intrusion sensor
//            level, runs exit and entry delay countdowns in whole seconds and
//            drives the siren generator enable while in ALARM.
//
// Parameters:
//   CLK_HZ          clock cycles per second (prescaler terminal count)
//   EXIT_DELAY_S    exit delay in seconds, 1..255
//   ENTRY_DELAY_S   entry delay in seconds, 1..255
//   ALARM_TIMEOUT_S alarm auto-silence time in seconds, 1..255
//                   (only active when ALARM_TIMEOUT_EN is defined)
//
// Ports:
//   clk        in   system clock, single domain
//   rst_n      in   synchronous active-low reset
//   arm        in   single-cycle arm request pulse
//   disarm     in   single-cycle valid-code pulse, highest priority
//   sensor     in   asynchronous intrusion level (1 = intrusion)
//   siren_en   out  high only in ALARM
//   armed      out  high in ARMED, ENTRY_DELAY and ALARM
//   state      out  state code: 0 DISARMED, 1 EXIT_DELAY, 2 ARMED,
//                   3 ENTRY_DELAY, 4 ALARM
//   countdown  out  seconds remaining in EXIT/ENTRY delay, else 0
//
// Build option:
//   ALARM_TIMEOUT_EN  when defined, ALARM times out after ALARM_TIMEOUT_S
//                     seconds and returns to ARMED. When undefined, ALARM
//                     holds until disarm or reset.
//
// Revision : 1.0 - initial release
// ============================================================================
module alarm_controller #(
    parameter int CLK_HZ          = 50_000_000,
    parameter int EXIT_DELAY_S    = 10,
    parameter int ENTRY_DELAY_S   = 10,
    parameter int ALARM_TIMEOUT_S = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       arm,
    input  logic       disarm,
    input  logic       sensor,
    output logic       siren_en,
    output logic       armed,
    output logic [2:0] state,
    output logic [7:0] countdown
);

    // Prescaler width; kept at least one bit so CLK_HZ=1 still elaborates.
    localparam int PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    localparam logic [PRE_W-1:0] c_PRE_MAX   = PRE_W'(CLK_HZ - 1);
    localparam logic [7:0]       c_EXIT_DLY  = 8'(EXIT_DELAY_S);
    localparam logic [7:0]       c_ENTRY_DLY = 8'(ENTRY_DELAY_S);
    localparam logic [7:0]       c_ALARM_DLY = 8'(ALARM_TIMEOUT_S);

    // Elaboration-time parameter range checks.
    if (CLK_HZ < 1) begin : g_chk_clk_hz
        $error("alarm_controller: CLK_HZ must be >= 1");
    end
    if (EXIT_DELAY_S < 1 || EXIT_DELAY_S > 255) begin : g_chk_exit
        $error("alarm_controller: EXIT_DELAY_S out of range 1..255");
    end
    if (ENTRY_DELAY_S < 1 || ENTRY_DELAY_S > 255) begin : g_chk_entry
        $error("alarm_controller: ENTRY_DELAY_S out of range 1..255");
    end
    if (ALARM_TIMEOUT_S < 1 || ALARM_TIMEOUT_S > 255) begin : g_chk_alarm
        $error("alarm_controller: ALARM_TIMEOUT_S out of range 1..255");
    end

    typedef enum logic [2:0] {
        S_DISARMED    = 3'd0,
        S_EXIT_DELAY  = 3'd1,
        S_ARMED       = 3'd2,
        S_ENTRY_DELAY = 3'd3,
        S_ALARM       = 3'd4
    } state_t;

    state_t           r_state;
    logic [PRE_W-1:0] r_pre;
    logic [7:0]       r_sec_cnt;
    logic             r_sens_meta;
    logic             r_sens_s;

    state_t           w_next;
    logic             w_timed;
    logic             w_tick;
    logic             w_expire;
    logic [7:0]       w_load;

    // ------------------------------------------------------------------
    // Timing engine decode
    // ------------------------------------------------------------------
    always_comb begin
        w_timed = 1'b0;
        case (r_state)
            S_EXIT_DELAY,
            S_ENTRY_DELAY: w_timed = 1'b1;
`ifdef ALARM_TIMEOUT_EN
            S_ALARM:       w_timed = 1'b1;
`endif
            default:       w_timed = 1'b0;
        endcase
    end

    assign w_tick   = w_timed && (r_pre == c_PRE_MAX);
    // The last second of a delay ends on the tick that sees sec_cnt==1.
    assign w_expire = w_tick && (r_sec_cnt == 8'd1);

    // ------------------------------------------------------------------
    // Next-state logic; disarm overrides everything.
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        if (disarm) begin
            w_next = S_DISARMED;
        end else begin
            case (r_state)
                S_DISARMED: begin
                    // Refuse to arm while the zone is open.
                    if (arm && !r_sens_s) begin
                        w_next = S_EXIT_DELAY;
                    end
                end
                S_EXIT_DELAY: begin
                    if (w_expire) begin
                        w_next = S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (r_sens_s) begin
                        w_next = S_ENTRY_DELAY;
                    end
                end
                S_ENTRY_DELAY: begin
                    if (w_expire) begin
                        w_next = S_ALARM;
                    end
                end
                S_ALARM: begin
`ifdef ALARM_TIMEOUT_EN
                    // Silence and re-arm; a still-open zone re-enters
                    // ENTRY_DELAY from ARMED on the following edge.
                    if (w_expire) begin
                        w_next = S_ARMED;
                    end
`else
                    w_next = S_ALARM;
`endif
                end
                default: w_next = S_DISARMED;
            endcase
        end
    end

    // Delay loaded into sec_cnt when entering a state.
    always_comb begin
        w_load = 8'd0;
        case (w_next)
            S_EXIT_DELAY:  w_load = c_EXIT_DLY;
            S_ENTRY_DELAY: w_load = c_ENTRY_DLY;
`ifdef ALARM_TIMEOUT_EN
            S_ALARM:       w_load = c_ALARM_DLY;
`endif
            default:       w_load = 8'd0;
        endcase
    end

`ifndef ALARM_TIMEOUT_EN
    // Alarm timeout constant is only consumed by the timeout build.
    logic w_unused_alarm_dly;
    assign w_unused_alarm_dly = ^c_ALARM_DLY;
`endif

    // ------------------------------------------------------------------
    // State, timing and synchronizer registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_DISARMED;
            r_pre       <= '0;
            r_sec_cnt   <= 8'd0;
            r_sens_meta <= 1'b0;
            r_sens_s    <= 1'b0;
        end else begin
            r_sens_meta <= sensor;
            r_sens_s    <= r_sens_meta;
            r_state     <= w_next;

            if (w_next != r_state) begin
                // Every state change restarts the second timer.
                r_pre     <= '0;
                r_sec_cnt <= w_load;
            end else if (w_timed) begin
                if (w_tick) begin
                    r_pre <= '0;
                    if (r_sec_cnt != 8'd0) begin
                        r_sec_cnt <= r_sec_cnt - 8'd1;
                    end
                end else begin
                    r_pre <= r_pre + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output decode from registered state only
    // ------------------------------------------------------------------
    assign state     = r_state;
    assign siren_en  = (r_state == S_ALARM);
    assign armed     = (r_state == S_ARMED) || (r_state == S_ENTRY_DELAY) ||
                       (r_state == S_ALARM);
    assign countdown = ((r_state == S_EXIT_DELAY) || (r_state == S_ENTRY_DELAY))
                       ? r_sec_cnt : 8'd0;

endmodule
`default_nettype wire

// File: tb/tb_alarm_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_alarm_controller
// Purpose  : Directed self-checking bench for alarm_controller with
//            CLK_HZ=10, EXIT_DELAY_S=3, ENTRY_DELAY_S=3, ALARM_TIMEOUT_S=2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alarm_controller;

    logic       clk;
    logic       rst_n;
    logic       arm;
    logic       disarm;
    logic       sensor;
    logic       siren_en;
    logic       armed;
    logic [2:0] state;
    logic [7:0] countdown;

    int n_checks;
    int n_fail;

    alarm_controller #(
        .CLK_HZ          (10),
        .EXIT_DELAY_S    (3),
        .ENTRY_DELAY_S   (3),
        .ALARM_TIMEOUT_S (2)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .arm       (arm),
        .disarm    (disarm),
        .sensor    (sensor),
        .siren_en  (siren_en),
        .armed     (armed),
        .state     (state),
        .countdown (countdown)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are
    // sampled 1 time unit after the edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Arm from DISARMED and ride out the 3 s exit delay (30 edges).
    task automatic arm_to_armed;
        arm = 1'b1;
        step(1);
        arm = 1'b0;
        chk("exit_state", state, 3'd1);
        chk("exit_cd_start", countdown, 8'd3);
        step(9);
        chk("exit_cd_t9", countdown, 8'd3);
        step(1);
        chk("exit_cd_t10", countdown, 8'd2);
        step(19);
        chk("exit_state_t29", state, 3'd1);
        step(1);
        chk("armed_state_t30", state, 3'd2);
        chk("armed_flag_t30", armed, 1'b1);
        chk("armed_cd_zero", countdown, 8'd0);
    endtask

    // Raise the sensor in ARMED and ride out the 3 s entry delay into ALARM.
    task automatic trigger_alarm;
        sensor = 1'b1;
        step(2);
        chk("sync_e0p1_state", state, 3'd2);
        step(1);
        chk("entry_state_e0p2", state, 3'd3);
        chk("entry_cd_start", countdown, 8'd3);
        step(29);
        chk("entry_state_p29", state, 3'd3);
        chk("entry_siren_off", siren_en, 1'b0);
        step(1);
        chk("alarm_state_p30", state, 3'd4);
        chk("alarm_siren_on", siren_en, 1'b1);
        chk("alarm_armed", armed, 1'b1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        arm      = 1'b0;
        disarm   = 1'b0;
        sensor   = 1'b0;

        // Reset held for two edges.
        step(2);
        chk("rst_state", state, 3'd0);
        chk("rst_siren", siren_en, 1'b0);
        chk("rst_armed", armed, 1'b0);
        chk("rst_cd", countdown, 8'd0);
        rst_n = 1'b1;
        step(1);
        chk("post_rst_state", state, 3'd0);

        // Arm refused while the zone is open.
        sensor = 1'b1;
        step(3);
        arm = 1'b1;
        step(1);
        arm = 1'b0;
        chk("arm_sensor_open", state, 3'd0);
        sensor = 1'b0;
        step(3);

        // Simultaneous arm and disarm keeps DISARMED.
        arm    = 1'b1;
        disarm = 1'b1;
        step(1);
        arm    = 1'b0;
        disarm = 1'b0;
        chk("arm_and_disarm", state, 3'd0);

        // Full path into ALARM, then disarm clears the siren on the next edge.
        arm_to_armed();
        trigger_alarm();
        disarm = 1'b1;
        step(1);
        disarm = 1'b0;
        chk("disarm_alarm_siren", siren_en, 1'b0);
        chk("disarm_alarm_state", state, 3'd0);
        sensor = 1'b0;
        step(3);

        // Disarm during ENTRY_DELAY once countdown reaches 2.
        arm_to_armed();
        sensor = 1'b1;
        step(3);
        chk("entry2_state", state, 3'd3);
        sensor = 1'b0;
        step(10);
        chk("entry2_cd2", countdown, 8'd2);
        disarm = 1'b1;
        step(1);
        disarm = 1'b0;
        chk("disarm_entry_state", state, 3'd0);
        chk("disarm_entry_armed", armed, 1'b0);
        chk("disarm_entry_cd", countdown, 8'd0);
        step(3);

        // Reset in the middle of ALARM.
        arm_to_armed();
        trigger_alarm();
        sensor = 1'b0;
        step(5);
        rst_n = 1'b0;
        step(1);
        chk("rst_alarm_state", state, 3'd0);
        chk("rst_alarm_siren", siren_en, 1'b0);
        chk("rst_alarm_armed", armed, 1'b0);
        chk("rst_alarm_cd", countdown, 8'd0);
        rst_n = 1'b1;
        step(3);
        chk("rst_alarm_stays", state, 3'd0);

        // ALARM with sensor released: timeout build vs. latched build.
        arm_to_armed();
        trigger_alarm();
        sensor = 1'b0;
`ifdef ALARM_TIMEOUT_EN
        step(19);
        chk("timeout_t19_state", state, 3'd4);
        step(1);
        chk("timeout_t20_state", state, 3'd2);
        chk("timeout_t20_siren", siren_en, 1'b0);
        chk("timeout_t20_armed", armed, 1'b1);
        step(5);
        chk("timeout_rearmed", state, 3'd2);
`else
        step(1000);
        chk("latched_state", state, 3'd4);
        chk("latched_siren", siren_en, 1'b1);
`endif
        disarm = 1'b1;
        step(1);
        disarm = 1'b0;
        chk("final_disarm", state, 3'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
